// File: rtl/vend_change.sv
// Newspaper vending controller: accumulates coin credit, vends once the price is met,
// then pays back any remainder one nickel per dispenser acknowledge.
module vend_change #(
  parameter int PRICE    = 3,
  parameter int CREDIT_W = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                newspaper,
  output logic                change_nickel,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject
);

  localparam int SUM_W = CREDIT_W + 1;
  localparam logic [SUM_W-1:0]    PRICE_SUM = SUM_W'(PRICE);
  localparam logic [CREDIT_W-1:0] PRICE_CR  = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] ONE_CR    = CREDIT_W'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, RETURN} state_t;

  state_t              state_reg, state_next;
  logic [CREDIT_W-1:0] credit_reg, credit_next;
  logic [1:0]          coin_q;
  logic                coin_reject_reg, coin_reject_next;
  logic                coin_event;
  logic [2:0]          coin_value;
  logic [SUM_W-1:0]    sum;

  // A held coin only counts on its first cycle.
  assign coin_event = (coin != 2'd0) && (coin_q == 2'd0);

  always_comb begin
    case (coin)
      2'd1:    coin_value = 3'd1;
      2'd2:    coin_value = 3'd2;
      2'd3:    coin_value = 3'd5;
      default: coin_value = 3'd0;
    endcase
  end

  // One bit wider than credit so the price compare can never see a wrapped value.
  assign sum = {1'b0, credit_reg} + SUM_W'(coin_event ? coin_value : 3'd0);

  always_comb begin
    state_next       = state_reg;
    credit_next      = credit_reg;
    coin_reject_next = 1'b0;
    case (state_reg)
      IDLE: begin
        credit_next = '0;
        if (coin_event) begin
          credit_next = sum[CREDIT_W-1:0];
          state_next  = (sum >= PRICE_SUM) ? VEND : COLLECT;
        end
      end
      COLLECT: begin
        credit_next = sum[CREDIT_W-1:0];
        if (sum >= PRICE_SUM) state_next = VEND;
        else if (cancel)      state_next = RETURN;
      end
      VEND: begin
        coin_reject_next = coin_event;
        credit_next      = credit_reg - PRICE_CR;
        state_next       = (credit_reg != PRICE_CR) ? RETURN : IDLE;
      end
      RETURN: begin
        coin_reject_next = coin_event;
        if (credit_reg == '0) begin
          state_next = IDLE;
        end else if (change_ack) begin
          credit_next = credit_reg - ONE_CR;
          if (credit_reg == ONE_CR) state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg       <= IDLE;
      credit_reg      <= '0;
      coin_q          <= 2'd0;
      coin_reject_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      credit_reg      <= credit_next;
      coin_q          <= coin;
      coin_reject_reg <= coin_reject_next;
    end
  end

  assign newspaper     = (state_reg == VEND);
  assign change_nickel = (state_reg == RETURN);
  assign credit        = credit_reg;
  assign coin_reject   = coin_reject_reg;

endmodule

// File: tb/tb_vend_change.sv
// Directed scoreboard bench for vend_change (PRICE=3, CREDIT_W=5): each step pushes the
// expected post-edge outputs, then pops and compares them after the clock edge.
module tb_vend_change;

  logic       clock;
  logic       reset;
  logic [1:0] coin;
  logic       cancel;
  logic       change_ack;
  logic       newspaper;
  logic       change_nickel;
  logic [4:0] credit;
  logic       coin_reject;

  typedef struct packed {
    logic [4:0] credit;
    logic       news;
    logic       cn;
    logic       rej;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  vend_change #(.PRICE(3), .CREDIT_W(5)) dut (
    .clock(clock),
    .reset(reset),
    .coin(coin),
    .cancel(cancel),
    .change_ack(change_ack),
    .newspaper(newspaper),
    .change_nickel(change_nickel),
    .credit(credit),
    .coin_reject(coin_reject)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then check.
  task automatic step(input string tag, input logic [1:0] c, input logic can, input logic ack,
                      input int e_credit, input logic e_news, input logic e_cn, input logic e_rej);
    exp_t e;
    coin       = c;
    cancel     = can;
    change_ack = ack;
    e.credit = 5'(e_credit);
    e.news   = e_news;
    e.cn     = e_cn;
    e.rej    = e_rej;
    sb.push_back(e);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_queue"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_credit"}, int'(credit), int'(e.credit));
      chk({tag, "_news"}, int'(newspaper), int'(e.news));
      chk({tag, "_cn"}, int'(change_nickel), int'(e.cn));
      chk({tag, "_rej"}, int'(coin_reject), int'(e.rej));
      $display("step %s: coin=%0d cancel=%0b ack=%0b -> credit=%0d news=%0b cn=%0b rej=%0b",
               tag, c, can, ack, credit, newspaper, change_nickel, coin_reject);
    end
  endtask

  initial begin
    reset = 1'b0; coin = 2'd0; cancel = 1'b0; change_ack = 1'b0;
    #1;
    chk("rst_credit", int'(credit), 0);
    chk("rst_news", int'(newspaper), 0);
    chk("rst_cn", int'(change_nickel), 0);
    chk("rst_rej", int'(coin_reject), 0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    // Three nickels with gaps
    step("n1", 2'd1, 0, 0, 1, 0, 0, 0);
    step("n1g", 2'd0, 0, 0, 1, 0, 0, 0);
    step("n2", 2'd1, 0, 0, 2, 0, 0, 0);
    step("n2g", 2'd0, 0, 0, 2, 0, 0, 0);
    step("n3", 2'd1, 0, 0, 3, 1, 0, 0);
    step("n3x", 2'd0, 0, 0, 0, 0, 0, 0);
    step("n3i", 2'd0, 0, 0, 0, 0, 0, 0);

    // Nickel then dime
    step("nd1", 2'd1, 0, 0, 1, 0, 0, 0);
    step("nd1g", 2'd0, 0, 0, 1, 0, 0, 0);
    step("nd2", 2'd2, 0, 0, 3, 1, 0, 0);
    step("nd2x", 2'd0, 0, 0, 0, 0, 0, 0);

    // Two dimes, one nickel of change
    step("dd1", 2'd2, 0, 0, 2, 0, 0, 0);
    step("dd1g", 2'd0, 0, 0, 2, 0, 0, 0);
    step("dd2", 2'd2, 0, 0, 4, 1, 0, 0);
    step("dd_ret", 2'd0, 0, 0, 1, 0, 1, 0);
    step("dd_wait", 2'd0, 0, 0, 1, 0, 1, 0);
    step("dd_ack", 2'd0, 0, 1, 0, 0, 0, 0);

    // Quarter with ack tied high; ack in IDLE/VEND ignored
    step("q_idle_ack", 2'd0, 0, 1, 0, 0, 0, 0);
    step("q", 2'd3, 0, 1, 5, 1, 0, 0);
    step("q_r2", 2'd0, 0, 1, 2, 0, 1, 0);
    step("q_r1", 2'd0, 0, 1, 1, 0, 1, 0);
    step("q_done", 2'd0, 0, 1, 0, 0, 0, 0);

    // Nickel then cancel; cancel in IDLE ignored
    step("c_idle", 2'd0, 1, 0, 0, 0, 0, 0);
    step("c_n", 2'd1, 0, 0, 1, 0, 0, 0);
    step("c_can", 2'd0, 1, 0, 1, 0, 1, 0);
    step("c_ack", 2'd0, 0, 1, 0, 0, 0, 0);

    // Completing payment beats cancel
    step("pb_d", 2'd2, 0, 0, 2, 0, 0, 0);
    step("pb_g", 2'd0, 0, 0, 2, 0, 0, 0);
    step("pb_nc", 2'd1, 1, 0, 3, 1, 0, 0);
    step("pb_x", 2'd0, 1, 0, 0, 0, 0, 0);

    // Coin in the same cycle as cancel is refunded too
    step("cc_n", 2'd1, 0, 0, 1, 0, 0, 0);
    step("cc_g", 2'd0, 0, 0, 1, 0, 0, 0);
    step("cc_nc", 2'd1, 1, 0, 2, 0, 1, 0);
    step("cc_a1", 2'd0, 0, 1, 1, 0, 1, 0);
    step("cc_a2", 2'd0, 0, 1, 0, 0, 0, 0);

    // Maximum credit PRICE+4 = 7
    step("mx_d", 2'd2, 0, 0, 2, 0, 0, 0);
    step("mx_g", 2'd0, 0, 0, 2, 0, 0, 0);
    step("mx_q", 2'd3, 0, 0, 7, 1, 0, 0);
    step("mx_r", 2'd0, 0, 0, 4, 0, 1, 0);
    step("mx_a1", 2'd0, 0, 1, 3, 0, 1, 0);
    step("mx_a2", 2'd0, 0, 1, 2, 0, 1, 0);
    step("mx_a3", 2'd0, 0, 1, 1, 0, 1, 0);
    step("mx_a4", 2'd0, 0, 1, 0, 0, 0, 0);

    // Held nickel counts once; dime in RETURN rejected; async reset mid-RETURN
    for (int i = 0; i < 5; i++) step("hold", 2'd1, 0, 0, 1, 0, 0, 0);
    step("h_can", 2'd0, 1, 0, 1, 0, 1, 0);
    step("h_rejd", 2'd2, 0, 0, 1, 0, 1, 1);
    step("h_rejx", 2'd0, 0, 0, 1, 0, 1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_credit", int'(credit), 0);
    chk("arst_news", int'(newspaper), 0);
    chk("arst_cn", int'(change_nickel), 0);
    chk("arst_rej", int'(coin_reject), 0);
    $display("async reset mid-RETURN: credit=%0d cn=%0b", credit, change_nickel);
    coin = 2'd2;
    @(posedge clock); #1;
    chk("arst_hold_credit", int'(credit), 0);
    reset = 1'b1;

    // Coin already held across reset release is a fresh event
    step("pr_d", 2'd2, 0, 0, 2, 0, 0, 0);
    step("pr_hold", 2'd2, 0, 0, 2, 0, 0, 0);
    step("pr_can", 2'd0, 1, 0, 2, 0, 1, 0);
    step("pr_a1", 2'd0, 0, 1, 1, 0, 1, 0);
    step("pr_a2", 2'd0, 0, 1, 0, 0, 0, 0);

    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
